// File: rtl/pulse_meas.sv
// Pulse period / high-time meter driven by upstream edge strobes, with a
// single-entry record register. Optional inactivity abort: PULSE_MEAS_TIMEOUT_EN.
module pulse_meas #(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 r_edge_i,
  input  logic                 f_edge_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_WIDTH-1:0] period_o,
  output logic [CNT_WIDTH-1:0] high_o,
  output logic                 sat_o,
  output logic                 overrun_o,
  output logic                 timeout_o
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  if (CNT_WIDTH < 2 || CNT_WIDTH > 32 ||
      64'(TIMEOUT_CYCLES) > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_param_check
    $error("pulse_meas: illegal CNT_WIDTH / TIMEOUT_CYCLES combination");
  end

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   period_q, period_d;
  logic [CNT_WIDTH-1:0]   high_q, high_d;
  logic                   sat_q, sat_d;
  logic                   capture;
  logic                   to_fire;

  logic                   valid_q, overrun_q, timeout_q;
  logic [CNT_WIDTH-1:0]   rec_period_q, rec_high_q;
  logic                   rec_sat_q;

  // A strobe only counts when its opposite is absent; a simultaneous pair is noise.
  logic rise, fall;
  assign rise = r_edge_i & ~f_edge_i;
  assign fall = f_edge_i & ~r_edge_i;

  logic                 period_max, high_max;
  logic [CNT_WIDTH-1:0] period_inc, high_inc;
  assign period_max = &period_q;
  assign high_max   = &high_q;
  assign period_inc = period_max ? period_q : period_q + ONE;
  assign high_inc   = high_max   ? high_q   : high_q + ONE;

  logic timeout_hit;
`ifdef PULSE_MEAS_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
  assign timeout_hit = (period_q == TIMEOUT_VAL);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    sat_d    = sat_q;
    capture  = 1'b0;
    to_fire  = 1'b0;

    if (en_i) begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d  = HIGH;
            period_d = ONE;
            high_d   = ONE;
            sat_d    = 1'b0;
          end
        end
        HIGH: begin
          if (rise) begin
            // Missed falling edge: restart the measurement without a record.
            period_d = ONE;
            high_d   = ONE;
            sat_d    = 1'b0;
          end else if (fall) begin
            state_d  = LOW;
            period_d = period_inc;
            sat_d    = sat_q | period_max;
          end else if (timeout_hit) begin
            state_d  = IDLE;
            period_d = '0;
            high_d   = '0;
            to_fire  = 1'b1;
          end else begin
            period_d = period_inc;
            high_d   = high_inc;
            sat_d    = sat_q | period_max | high_max;
          end
        end
        LOW: begin
          if (rise) begin
            capture  = 1'b1;
            state_d  = HIGH;
            period_d = ONE;
            high_d   = ONE;
            sat_d    = 1'b0;
          end else if (timeout_hit) begin
            state_d  = IDLE;
            period_d = '0;
            high_d   = '0;
            to_fire  = 1'b1;
          end else begin
            period_d = period_inc;
            sat_d    = sat_q | period_max;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values.
    if (!rst_ni) begin
      state_q      <= IDLE;
      period_q     <= '0;
      high_q       <= '0;
      sat_q        <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      rec_period_q <= '0;
      rec_high_q   <= '0;
      rec_sat_q    <= 1'b0;
    end else if (clr_i) begin
      state_q   <= IDLE;
      period_q  <= '0;
      high_q    <= '0;
      sat_q     <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      high_q    <= high_d;
      sat_q     <= sat_d;
      timeout_q <= to_fire;
      if (capture) begin
        if (valid_q && !ready_i) begin
          // Consumer still holds the previous record: keep it, flag the loss.
          overrun_q <= 1'b1;
        end else begin
          rec_period_q <= period_q;
          rec_high_q   <= high_q;
          rec_sat_q    <= sat_q;
          valid_q      <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o   = valid_q;
  assign period_o  = rec_period_q;
  assign high_o    = rec_high_q;
  assign sat_o     = rec_sat_q;
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas: scoreboard of expected records on the main
// instance, plus a 4-bit instance (saturation) and a short-timeout instance.
module tb_pulse_meas;

`ifdef PULSE_MEAS_TIMEOUT_EN
  localparam int TO_EN = 1;
`else
  localparam int TO_EN = 0;
`endif

  logic clk, rst_n;

  // main instance, default parameters
  logic        clr, en, r_edge, f_edge, ready;
  logic        valid, sat, overrun, timeout;
  logic [15:0] period, high;

  // auxiliary instances share one stimulus set
  logic        a_clr, a_en, a_r, a_f, a_ready;
  logic        s_valid, s_sat, s_overrun, s_timeout;
  logic [3:0]  s_period, s_high;
  logic        t_valid, t_sat, t_overrun, t_timeout;
  logic [15:0] t_period, t_high;

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    logic        sat;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   sat_to = 0;
  int   to_cnt = 0;

  pulse_meas u_dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .en_i(en),
    .r_edge_i(r_edge), .f_edge_i(f_edge), .valid_o(valid), .ready_i(ready),
    .period_o(period), .high_o(high), .sat_o(sat), .overrun_o(overrun),
    .timeout_o(timeout)
  );

  pulse_meas #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(15)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .en_i(a_en),
    .r_edge_i(a_r), .f_edge_i(a_f), .valid_o(s_valid), .ready_i(a_ready),
    .period_o(s_period), .high_o(s_high), .sat_o(s_sat), .overrun_o(s_overrun),
    .timeout_o(s_timeout)
  );

  pulse_meas #(.CNT_WIDTH(16), .TIMEOUT_CYCLES(10)) u_to (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(a_clr), .en_i(a_en),
    .r_edge_i(a_r), .f_edge_i(a_f), .valid_o(t_valid), .ready_i(a_ready),
    .period_o(t_period), .high_o(t_high), .sat_o(t_sat), .overrun_o(t_overrun),
    .timeout_o(t_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_rec(input int p, input int h, input logic s);
    rec_t e;
    e.period = 16'(p);
    e.high   = 16'(h);
    e.sat    = s;
    exp_q.push_back(e);
  endtask

  // One clock: sample on the falling edge, then return just after the rising edge.
  task automatic tick();
    rec_t e;
    @(negedge clk);
    if (valid && ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=record %0d/%0d expected=no record", period, high);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_period", period, e.period);
        check("sb_high", high, e.high);
        check("sb_sat", sat, e.sat);
      end
    end
    if (s_timeout) sat_to++;
    if (t_timeout) to_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic r, input logic f);
    r_edge = r;
    f_edge = f;
    tick();
    r_edge = 1'b0;
    f_edge = 1'b0;
  endtask

  task automatic astep(input logic r, input logic f);
    a_r = r;
    a_f = f;
    tick();
    a_r = 1'b0;
    a_f = 1'b0;
  endtask

  task automatic pulse(input int h, input int l);
    step(1'b1, 1'b0);
    repeat (h - 1) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (l - 1) step(1'b0, 1'b0);
  endtask

  task automatic apulse(input int h, input int l);
    astep(1'b1, 1'b0);
    repeat (h - 1) astep(1'b0, 1'b0);
    astep(1'b0, 1'b1);
    repeat (l - 1) astep(1'b0, 1'b0);
  endtask

  initial begin
    int sat0, to0;
    rst_n = 1'b0;
    clr = 1'b0; en = 1'b1; r_edge = 1'b0; f_edge = 1'b0; ready = 1'b1;
    a_clr = 1'b0; a_en = 1'b1; a_r = 1'b0; a_f = 1'b0; a_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_period", period, 0);
    check("rst_high", high, 0);
    check("rst_sat", sat, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    rst_n = 1'b1;
    tick();

    // repeated 5-high / 3-low waveform, then other shapes
    pulse(5, 3);
    for (int i = 0; i < 3; i++) begin
      exp_rec(8, 5, 1'b0);
      pulse(5, 3);
    end
    exp_rec(8, 5, 1'b0);
    pulse(2, 7);
    exp_rec(9, 2, 1'b0);
    pulse(1, 1);
    exp_rec(2, 1, 1'b0);
    step(1'b1, 1'b0);

    // missed falling edge: rising, rising 4 later, falling 2 later, rising 3 later
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    exp_rec(5, 2, 1'b0);
    step(1'b1, 1'b0);

    // simultaneous strobes and a falling strobe in LOW are both ignored
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    exp_rec(5, 3, 1'b0);
    step(1'b1, 1'b0);

    // enable low: measurement frozen, handshake still drains the record
    en = 1'b0;
    repeat (3) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    check("en_low_drain", valid, 0);
    en = 1'b1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    exp_rec(4, 2, 1'b0);
    step(1'b1, 1'b0);

    // overrun: consumer stalls across three captures
    step(1'b0, 1'b0);
    ready = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    pulse(3, 3);
    check("ovr_first_no_flag", overrun, 0);
    pulse(2, 2);
    check("ovr_valid_held", valid, 1);
    check("ovr_period_held", period, 6);
    check("ovr_high_held", high, 4);
    check("ovr_flag", overrun, 1);
    step(1'b1, 1'b0);
    check("ovr_period_stable", period, 6);
    exp_rec(6, 4, 1'b0);
    ready = 1'b1;
    step(1'b0, 1'b0);
    check("ovr_valid_cleared", valid, 0);
    step(1'b0, 1'b0);
    check("ovr_sticky", overrun, 1);

    // clear while a record is pending and the FSM is in LOW
    ready = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("clr_pre_valid", valid, 1);
    clr = 1'b1;
    step(1'b1, 1'b0);
    clr = 1'b0;
    check("clr_valid", valid, 0);
    check("clr_overrun", overrun, 0);
    ready = 1'b1;
    step(1'b0, 1'b1);
    pulse(4, 2);
    exp_rec(6, 4, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("sb_after_clr", exp_q.size(), 0);

    // reset mid-measurement discards the partial period
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_period", period, 0);
    tick();
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    pulse(3, 2);
    exp_rec(5, 3, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // 4-bit counters saturate (with timeout enabled the limit aborts first)
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    sat0 = sat_to;
    apulse(20, 2);
    astep(1'b1, 1'b0);
    check("sat_valid", s_valid, (TO_EN != 0) ? 0 : 1);
    check("sat_period", s_period, (TO_EN != 0) ? 0 : 15);
    check("sat_high", s_high, (TO_EN != 0) ? 0 : 15);
    check("sat_flag", s_sat, (TO_EN != 0) ? 0 : 1);
    check("sat_timeouts", sat_to - sat0, TO_EN);

    // inactivity after a single rising edge
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    to0 = to_cnt;
    astep(1'b1, 1'b0);
    repeat (20) astep(1'b0, 1'b0);
    check("to_pulses", to_cnt - to0, TO_EN);
    check("to_no_record", t_valid, 0);
    check("to_pulse_ended", t_timeout, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
